// File: rtl/ro_meas_pkg.sv
// Purpose: shared register map, bit positions and FSM encoding for the ring-oscillator frequency meter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ro_meas_pkg;

  // Register offsets within the 16-byte block.
  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_WINDOW = 4'h4;
  localparam logic [3:0] REG_COUNT  = 4'h8;
  localparam logic [3:0] REG_STATUS = 4'hC;

  // CTRL bit positions.
  localparam int CTRL_GO      = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_SEL_LSB = 4;

  // STATUS bit positions.
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_OVF  = 2;

  // Shortest settle time that still flushes the synchronizer and edge detector.
  localparam int MIN_SETTLE = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_COUNT  = 2'd2,
    S_DONE   = 2'd3
  } meas_state_e;

endpackage

// File: rtl/ro_sync_edge.sv
// Purpose: 2-flop synchronizer for one asynchronous tap followed by a registered rising-edge pulse.
// Latency: 3 clk_i cycles from input edge to rise_o pulse.
// Backpressure: none; one pulse per synchronized rising edge.
// Ports: clk_i/rst_i clock and sync active-high reset, d_i async tap, rise_o one-cycle edge pulse.
module ro_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic meta_q, sync_q, sync_dly_q, rise_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q     <= 1'b0;
      sync_q     <= 1'b0;
      sync_dly_q <= 1'b0;
      rise_q     <= 1'b0;
    end else begin
      meta_q     <= d_i;
      sync_q     <= meta_q;
      sync_dly_q <= sync_q;
      rise_q     <= sync_q & ~sync_dly_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/ro_freq_meter.sv
// Purpose: Wishbone frequency meter; counts rising edges of one selected ring-oscillator tap over a gate window.
// Latency: ack/read data 1 cycle after request; irq SETTLE_CYCLES + WINDOW + 2 cycles after the go ack.
// Backpressure: one ack per request, never back-to-back; out-of-block addresses are never acked.
// Ports: wb_* / wbs_* Wishbone slave, ro_in async taps, ro_start oscillator enable, irq = STATUS.done.
module ro_freq_meter
  import ro_meas_pkg::*;
#(
  parameter int          NUM_RO        = 10,
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
  parameter int          SETTLE_CYCLES = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [NUM_RO-1:0] ro_in,
  output logic              ro_start,
  output logic              irq
);

  // Too-short settle values are raised to the minimum that flushes the edge path.
  localparam int          SETTLE_EFF  = (SETTLE_CYCLES < MIN_SETTLE) ? MIN_SETTLE : SETTLE_CYCLES;
  localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_EFF - 1);

  meas_state_e state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] window_q, run_win_q, cnt_q, count_q, rdata;
  logic [3:0]  sel_q, run_sel_q;
  logic        go_q, abort_q, done_q, ovf_q, ack_q;
  logic [31:0] dat_q;
  logic        req, wr_en, rd_en, go_ok, busy, rise;
  logic [15:0] taps_pad;

  assign req   = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wr_en = req & ~ack_q & wbs_we_i;
  assign rd_en = req & ~ack_q & ~wbs_we_i;
  assign go_ok = go_q & ~abort_q;   // abort in the same write suppresses go
  assign busy  = (state_q != S_IDLE);

  // Mux before the synchronizer; unused upper slots read as constant 0.
  assign taps_pad = 16'(ro_in);

  ro_sync_edge u_sync (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .d_i    (taps_pad[run_sel_q]),
    .rise_o (rise)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (go_ok) begin
          if (window_q == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SETTLE;
            timer_d = SETTLE_LOAD;
          end
        end
      end
      S_SETTLE: begin
        if (abort_q) begin
          state_d = S_IDLE;
        end else if (timer_q == '0) begin
          state_d = S_COUNT;
          timer_d = run_win_q - 32'd1;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      S_COUNT: begin
        if (abort_q) begin
          state_d = S_IDLE;
        end else if (timer_q == '0) begin
          state_d = S_DONE;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      default: state_d = S_IDLE;   // S_DONE lasts exactly one cycle
    endcase
  end

  always_comb begin
    rdata = '0;
    case (wbs_adr_i[3:0])
      REG_CTRL:   rdata[CTRL_SEL_LSB +: 4] = sel_q;
      REG_WINDOW: rdata = window_q;
      REG_COUNT:  rdata = count_q;
      REG_STATUS: begin
        rdata[ST_BUSY] = busy;
        rdata[ST_DONE] = done_q;
        rdata[ST_OVF]  = ovf_q;
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      window_q  <= '0;
      run_win_q <= '0;
      sel_q     <= '0;
      run_sel_q <= '0;
      cnt_q     <= '0;
      count_q   <= '0;
      go_q      <= 1'b0;
      abort_q   <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      ack_q   <= req & ~ack_q;
      dat_q   <= rd_en ? rdata : '0;
      state_q <= state_d;
      timer_q <= timer_d;
      // go/abort are one-cycle pulses consumed by the FSM on the following edge.
      go_q    <= 1'b0;
      abort_q <= 1'b0;

      if (wr_en) begin
        case (wbs_adr_i[3:0])
          REG_CTRL: begin
            if (wbs_sel_i[0]) begin
              go_q    <= wbs_dat_i[CTRL_GO];
              abort_q <= wbs_dat_i[CTRL_ABORT];
              sel_q   <= wbs_dat_i[CTRL_SEL_LSB +: 4];
            end
          end
          REG_WINDOW: begin
            for (int b = 0; b < 4; b++) begin
              if (wbs_sel_i[b]) window_q[8*b +: 8] <= wbs_dat_i[8*b +: 8];
            end
          end
          REG_STATUS: begin
            if (wbs_sel_i[0]) begin
              if (wbs_dat_i[ST_DONE]) done_q <= 1'b0;
              if (wbs_dat_i[ST_OVF])  ovf_q  <= 1'b0;
            end
          end
          default: ;
        endcase
      end

      // Start of run: freeze sel/window for this run and clear the accumulator.
      if (state_q == S_IDLE && go_ok) begin
        run_sel_q <= sel_q;
        run_win_q <= window_q;
        cnt_q     <= '0;
        if (window_q != '0) begin
          count_q <= '0;
          ovf_q   <= 1'b0;
        end
      end

      // Saturating edge accumulation; set of ovf is ordered after its clears.
      if (state_q == S_COUNT && !abort_q && rise) begin
        if (&cnt_q) ovf_q <= 1'b1;
        else        cnt_q <= cnt_q + 32'd1;
      end

      // DONE set is ordered after the W1C so a simultaneous clear loses.
      if (state_q == S_DONE) begin
        count_q <= cnt_q;
        done_q  <= 1'b1;
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign ro_start  = (state_q == S_SETTLE) || (state_q == S_COUNT);
  assign irq       = done_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
module tb_ro_freq_meter;

  localparam int          NUM_RO = 10;
  localparam int          SETTLE = 8;
  localparam logic [31:0] BASE   = 32'h3000_0000;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i;
  logic              wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i, wbs_dat_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic [NUM_RO-1:0] ro_in;
  logic              ro_start, irq;

  ro_freq_meter #(
    .NUM_RO        (NUM_RO),
    .BASE_ADDR     (BASE),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .ro_in     (ro_in),
    .ro_start  (ro_start),
    .irq       (irq)
  );

  initial forever #5 wb_clk_i = ~wb_clk_i;

  int cyc = 0;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int ack_cyc;
  logic [NUM_RO-1:0] tap_mask = '0;

  // Tap stimulus: selected taps toggle every 5 clocks (period 10 clocks).
  initial begin
    logic tog;
    int   ph;
    tog   = 1'b0;
    ph    = 0;
    ro_in = '0;
    forever begin
      @(posedge wb_clk_i);
      #2;
      ph = (ph == 4) ? 0 : ph + 1;
      if (ph == 0) tog = ~tog;
      ro_in = tap_mask & {NUM_RO{tog}};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input logic [31:0] obs, input int lo, input int hi);
    tests++;
    assert (int'(obs) >= lo && int'(obs) <= hi) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the acking edge.
  task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                         input logic [3:0] sel, output logic [31:0] rdat);
    logic got;
    got  = 1'b0;
    rdat = 'x;
    wbs_adr_i = adr;
    wbs_we_i  = we;
    wbs_dat_i = wdat;
    wbs_sel_i = sel;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    for (int i = 0; i < 16 && !got; i++) begin
      @(posedge wb_clk_i);
      #1;
      if (wbs_ack_o) begin
        got     = 1'b1;
        rdat    = wbs_dat_o;
        ack_cyc = cyc;
      end
    end
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
    check("wb_ack", {31'b0, got}, 32'd1);
  endtask

  task automatic wb_wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] dummy;
    wb_xfer(BASE | {28'b0, off}, 1'b1, d, sel, dummy);
  endtask

  task automatic rd_check(input string tag, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] r;
    wb_xfer(BASE | {28'b0, off}, 1'b0, 32'h0, 4'hF, r);
    check(tag, r, exp);
  endtask

  task automatic no_ack_check(input string tag, input logic [31:0] adr);
    int acks;
    acks = 0;
    wbs_adr_i = adr;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'hF;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    repeat (6) begin
      @(posedge wb_clk_i);
      #1;
      if (wbs_ack_o) acks++;
    end
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    check(tag, acks, 0);
  endtask

  // Waits for irq; reports cycles since go ack and flags ro_start low inside SETTLE+COUNT.
  task automatic wait_irq(input string tag, input int start, input int win, output int delay);
    logic got;
    int   low;
    got   = 1'b0;
    low   = 0;
    delay = -1;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(posedge wb_clk_i);
      #1;
      if (cyc - start >= 1 && cyc - start <= SETTLE + win && !ro_start) low++;
      if (irq) begin
        got   = 1'b1;
        delay = cyc - start;
      end
    end
    check({tag, "_irq_seen"}, {31'b0, got}, 32'd1);
    check({tag, "_ro_start_low_cycles"}, low, 0);
  endtask

  initial begin
    int t0, d;
    wb_rst_i  = 1'b1;
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'h0;
    wbs_adr_i = '0;
    wbs_dat_i = '0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("rst_ack", {31'b0, wbs_ack_o}, 0);
    check("rst_dat", wbs_dat_o, 0);
    check("rst_ro_start", {31'b0, ro_start}, 0);
    check("rst_irq", {31'b0, irq}, 0);
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i);
    #1;
    rd_check("rst_ctrl", 4'h0, 32'h0);
    rd_check("rst_window", 4'h4, 32'h0);
    rd_check("rst_count", 4'h8, 32'h0);
    rd_check("rst_status", 4'hC, 32'h0);

    // Nominal run: sel=3, WINDOW=1000, tap period 10 -> ~100 edges.
    tap_mask = 10'b00_0000_1000;
    wb_wr(4'h4, 32'd1000, 4'hF);
    wb_wr(4'h0, 32'h31, 4'h1);
    t0 = ack_cyc;
    wait_irq("run1000", t0, 1000, d);
    check("run1000_irq_delay", d, 1010);
    rd_check("run1000_status_busy", 4'hC, 32'h2);
    begin
      logic [31:0] r;
      wb_xfer(BASE | 32'h8, 1'b0, 32'h0, 4'hF, r);
      check_range("run1000_count", r, 99, 101);
    end
    wb_wr(4'hC, 32'h2, 4'h1);
    check("w1c_irq_low", {31'b0, irq}, 0);

    // WINDOW=0: straight to DONE, irq two cycles after ack.
    wb_wr(4'h4, 32'd0, 4'hF);
    wb_wr(4'h0, 32'h31, 4'h1);
    @(posedge wb_clk_i);
    #1;
    check("win0_irq_at1", {31'b0, irq}, 0);
    @(posedge wb_clk_i);
    #1;
    check("win0_irq_at2", {31'b0, irq}, 1);
    rd_check("win0_count", 4'h8, 32'h0);
    rd_check("win0_status", 4'hC, 32'h2);
    wb_wr(4'hC, 32'h2, 4'h1);
    check("win0_clear_irq", {31'b0, irq}, 0);

    // Abort mid-run.
    wb_wr(4'h4, 32'd500, 4'hF);
    wb_wr(4'h0, 32'h31, 4'h1);
    repeat (100) @(posedge wb_clk_i);
    #1;
    wb_wr(4'h0, 32'h32, 4'h1);
    @(posedge wb_clk_i);
    #1;
    check("abort_ro_start", {31'b0, ro_start}, 0);
    rd_check("abort_status", 4'hC, 32'h0);
    rd_check("abort_count", 4'h8, 32'h0);
    check("abort_irq", {31'b0, irq}, 0);

    // Saturation via backdoor preload during SETTLE.
    wb_wr(4'h4, 32'd1000, 4'hF);
    wb_wr(4'h0, 32'h31, 4'h1);
    t0 = ack_cyc;
    @(posedge wb_clk_i);
    #1;
    dut.cnt_q = 32'hFFFF_FFF0;
    wait_irq("ovf", t0, 1000, d);
    rd_check("ovf_count", 4'h8, 32'hFFFF_FFFF);
    rd_check("ovf_status", 4'hC, 32'h6);
    wb_wr(4'hC, 32'h6, 4'h1);
    rd_check("ovf_cleared", 4'hC, 32'h0);

    // Out-of-block accesses.
    no_ack_check("noack_base_0x10", BASE + 32'h10);
    no_ack_check("noack_other_base", 32'h4000_0000);

    // go and WINDOW write while busy must not disturb the run.
    wb_wr(4'h4, 32'd200, 4'hF);
    wb_wr(4'h0, 32'h31, 4'h1);
    t0 = ack_cyc;
    repeat (20) @(posedge wb_clk_i);
    #1;
    wb_wr(4'h4, 32'd50, 4'hF);
    wb_wr(4'h0, 32'h31, 4'h1);
    wait_irq("busy_go", t0, 200, d);
    check("busy_go_irq_delay", d, 210);
    begin
      logic [31:0] r;
      wb_xfer(BASE | 32'h8, 1'b0, 32'h0, 4'hF, r);
      check_range("busy_go_count", r, 19, 21);
    end
    wb_wr(4'hC, 32'h2, 4'h1);

    // sel=12 is out of range: all taps toggling still measure 0; uses WINDOW=50.
    tap_mask = '1;
    wb_wr(4'h0, 32'hC1, 4'h1);
    t0 = ack_cyc;
    wait_irq("sel12", t0, 50, d);
    check("sel12_irq_delay", d, 60);
    rd_check("sel12_count", 4'h8, 32'h0);
    wb_wr(4'hC, 32'h2, 4'h1);

    // Byte enables: only byte 0 of WINDOW and CTRL writes without sel[0] are dropped.
    wb_wr(4'h4, 32'hFFFF_FFFF, 4'h1);
    rd_check("window_byte0", 4'h4, 32'h0000_00FF);
    wb_wr(4'h0, 32'h51, 4'hE);
    rd_check("ctrl_sel0_masked", 4'h0, 32'hC0);
    rd_check("ctrl_sel0_no_go", 4'hC, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ro_freq_meter.md
# ro_freq_meter

Wishbone-accessible frequency meter that consumes the ring-oscillator tap outputs and reports an edge count over a programmable gate window. It sits directly downstream of the ring-oscillator bank in the user project wrapper, in parallel with the pad output muxes. It selects one tap, drives the oscillator `start` enable, counts its rising edges, and raises an interrupt when the result is ready. Each tap is assumed pre-divided so that f_ro < f_clk/2; the divider is out of scope.

## Interface

Parameters:

- `NUM_RO`, 10: number of tap inputs. Must be ≤ 16.
- `BASE_ADDR`, 32'h3000_0000: register block base. Bits [3:0] are ignored.
- `SETTLE_CYCLES`, 8: cycles waited after enable/select before counting. Must be ≥ 4.

Ports (one clock; reset is synchronous and active-high):

- `wb_clk_i` input 1: sole clock.
- `wb_rst_i` input 1: synchronous, active-high reset.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` input 1 each: Wishbone strobe, cycle, write.
- `wbs_sel_i` input 4: byte enables.
- `wbs_adr_i` input 32: address.
- `wbs_dat_i` input 32: write data.
- `wbs_ack_o` output 1: acknowledge.
- `wbs_dat_o` output 32: read data.
- `ro_in` input NUM_RO: asynchronous oscillator taps.
- `ro_start` output 1: oscillator enable, wired to `start` of every oscillator.
- `irq` output 1: level interrupt, equal to STATUS.done.

## Operation

- Register map (offset from BASE):
  - 0x0 CTRL, RW:
    - [0] go, self-clearing, reads 0.
    - [1] abort, self-clearing, reads 0.
    - [7:4] sel.
  - 0x4 WINDOW, RW 32-bit. Gate length in clocks. Byte enables honoured.
  - 0x8 COUNT, RO. Last result.
  - 0xC STATUS:
    - [0] busy, RO.
    - [1] done, write 1 to clear.
    - [2] ovf, write 1 to clear.
- Only CTRL byte 0 is writable; sel is ignored unless wbs_sel_i[0]=1. Writes to RO fields are discarded.
- sel ≥ NUM_RO selects constant 0, which measures as count 0.
- FSM states: IDLE → SETTLE → COUNT → DONE → IDLE.
  - IDLE: `ro_start`=0. A go write with WINDOW≠0 does three things: clear COUNT, clear ovf, and go to SETTLE.
  - go with WINDOW=0: go straight to DONE. COUNT=0 and done=1.
  - SETTLE: `ro_start`=1. Wait SETTLE_CYCLES to flush the synchronizer, then go to COUNT.
  - COUNT: `ro_start`=1. Add each detected rising edge of `ro_in[sel]`. Leave after exactly WINDOW cycles.
  - DONE: lasts one cycle. Set done, latch the count into COUNT, drop `ro_start`, return to IDLE.
- go while busy is ignored. sel and WINDOW writes while busy are accepted into the registers but affect only the next run; the run in progress uses values latched at go.
- abort in SETTLE or COUNT: go to IDLE next cycle. done is not set and COUNT is left unchanged.
- go and abort set in the same write: abort wins; the FSM stays in or returns to IDLE.
- Counter saturates at 32'hFFFF_FFFF and sets ovf.
- Wishbone:
  - A request is `stb & cyc` with address bits [31:4] matching BASE_ADDR[31:4].
  - ack is a one-cycle pulse in the cycle after the request. No ack while ack is already high.
  - Out-of-range addresses are never acked.
  - `wbs_dat_o` is 0 whenever ack=0.
- A W1C write to done in the same cycle DONE sets it: the set wins.

## Timing

- Reset values: `wbs_ack_o`=0, `wbs_dat_o`=0, `ro_start`=0, `irq`=0. All registers are 0 and the FSM is in IDLE.
- Reset mid-run returns to IDLE on the next edge and drops `ro_start`.
- Write acked at edge T → state SETTLE from T+1 → COUNT from T+1+SETTLE_CYCLES → DONE after WINDOW COUNT cycles → `irq` high on the next cycle.
- Total from ack to `irq` = SETTLE_CYCLES + WINDOW + 2 cycles.
- Edge path: 2-flop synchronizer, then a registered edge detect, so 3 cycles of latency.
  - Edges whose detect pulse falls inside the COUNT window are counted.
  - This is a fixed offset and is not compensated.
- Read latency is 1 cycle. Reading COUNT in the same cycle as the DONE update returns the old value.

## Structure

- Shared package `ro_meas_pkg` holds:
  - the register offsets and STATUS/CTRL bit positions;
  - the FSM state enum;
  - the minimum SETTLE constant.
- Sub-module `ro_sync_edge`: 2-flop synchronizer plus rising-edge pulse, one instance on the muxed tap.
- The tap mux sits before the synchronizer, so only one synchronizer is needed.

## Test plan

- Reset, then read all 4 registers → all 0. `ro_start`=0, `irq`=0.
- sel=3, WINDOW=1000, `ro_in[3]` toggling every 5 clocks (period 10), go → COUNT=100 ±1. `irq` rises exactly 1010 cycles after ack. `ro_start` is high throughout SETTLE and COUNT.
- WINDOW=0, go → done=1 and COUNT=0 after 2 cycles. Writing 0x2 to STATUS → `irq`=0.
- Start a WINDOW=500 run, write abort at cycle 100 → IDLE, done=0, COUNT keeps its prior value, `ro_start`=0 next cycle.
- Force counter preload 32'hFFFF_FFF0 (backdoor), run 100 edges → COUNT=32'hFFFF_FFFF, ovf=1.
- Access at BASE+0x10 and at another base → no ack. A go write during busy → run unaffected. sel=12 → COUNT=0.
